// File: rtl/rshp_pkg.sv
// Shared types and width helpers for the reshaper drain side.
//   bytew/vbytew : byte-count widths derived from the datapath width
//   rshp_state_t : read-controller FSM states
//   rshp_ent_t   : output-queue entry {data, nbyte, last}
package rshp_pkg;

    localparam int unsigned RSHP_DW = 512;

    function automatic int unsigned bytew(input int unsigned dw);
        return $clog2(dw / 8) + 1;
    endfunction

    function automatic int unsigned vbytew(input int unsigned dw);
        return $clog2(dw / 4) + 1;
    endfunction

    localparam int unsigned BYTEW  = bytew(RSHP_DW);
    localparam int unsigned VBYTEW = vbytew(RSHP_DW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rshp_state_t;

    typedef struct packed {
        logic [RSHP_DW-1:0] data;
        logic [BYTEW-1:0]   nbyte;
        logic               last;
    } rshp_ent_t;

endpackage

// File: rtl/rshp_skid2.sv
// Two-entry valid/ready queue with occupancy output.
//   in_vld/in_rdy/in_data    : push side (in_rdy low only when full)
//   out_vld/out_rdy/out_data : pop side, head held in a register
//   occ                      : current occupancy 0..2
module rshp_skid2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] e0_q;
    logic [W-1:0] e1_q;
    logic [1:0]   occ_q;
    logic         push;
    logic         pop;

    assign in_rdy   = (occ_q != 2'd2);
    assign out_vld  = (occ_q != 2'd0);
    assign out_data = e0_q;
    assign occ      = occ_q;
    assign push     = in_vld & in_rdy;
    assign pop      = out_vld & out_rdy;

    // e0 is always the head; e1 only holds the second entry when full.
    always_ff @(posedge clk) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push) begin
                        e0_q  <= in_data;
                        occ_q <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b10: begin
                            e1_q  <= in_data;
                            occ_q <= 2'd2;
                        end
                        2'b01:   occ_q <= 2'd0;
                        2'b11:   e0_q  <= in_data;
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (pop) begin
                        e0_q  <= e1_q;
                        occ_q <= 2'd1;
                    end
                end
                default: occ_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/rshp_rd_ctrl.sv
// Drain-side controller for the byte-granular reshaper FIFO.
// Slices each command's byte total into chunk-sized beats, reading the
// FIFO only as far as the command needs.
//   cmd_*   : command stream (total bytes, chunk bytes per beat)
//   ffr*    : FIFO read port (request/size out, data/valid back one cycle later)
//   ffvbyte : bytes currently available in the FIFO
//   out_*   : output beat stream (valid/ready), out_last on the final beat
//   done    : one-cycle pulse when the command has fully drained
module rshp_rd_ctrl
    import rshp_pkg::*;
#(
    parameter  int unsigned DW   = RSHP_DW,
    parameter  int unsigned LENW = 24,
    localparam int unsigned BW   = bytew(DW),
    localparam int unsigned VBW  = vbytew(DW)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_vld,
    output logic            cmd_rdy,
    input  logic [LENW-1:0] cmd_total_byte,
    input  logic [BW-1:0]   cmd_chunk_byte,
    input  logic [VBW-1:0]  ffvbyte,
    input  logic            ffrempty,
    output logic            ffrreq,
    output logic [BW-1:0]   ffrbyte,
    input  logic [DW-1:0]   ffrdata,
    input  logic            ffrvld,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [DW-1:0]   out_data,
    output logic [BW-1:0]   out_byte,
    output logic            out_last,
    output logic            done
);

    localparam int unsigned NB = DW / 8;

    rshp_state_t     state_q;
    rshp_state_t     state_d;
    logic [LENW-1:0] rem_q;
    logic [BW-1:0]   chunk_q;
    logic            pend_q;
    logic [BW-1:0]   pend_n_q;
    logic            pend_last_q;

    logic [BW-1:0]   n_c;
    logic            ffv_ok;
    logic            credit_ok;
    logic            accept;
    logic            push;
    logic            pop;
    logic [1:0]      occ;
    logic            q_out_vld;
    logic            unused_in_rdy;
    logic            unused_ffrempty;
    logic [DW-1:0]   masked;
    rshp_ent_t       push_ent;
    rshp_ent_t       head_ent;

    assign unused_ffrempty = ffrempty;

    // Request size: a full chunk, or whatever remains if that is smaller.
    assign n_c    = (LENW'(chunk_q) < rem_q) ? chunk_q : BW'(rem_q);
    assign ffv_ok = (ffvbyte >= VBW'(n_c));
    assign pop    = q_out_vld & out_rdy;
    // Queue slots already spoken for (stored + in flight) must stay below 2.
    assign credit_ok = (({1'b0, occ} + 3'(pend_q) - 3'(pop)) < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_rdy = 1'b0;
        ffrreq  = 1'b0;
        ffrbyte = '0;
        done    = 1'b0;
        accept  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    cmd_rdy = 1'b1;
                    if (cmd_vld) begin
                        accept  = 1'b1;
                        state_d = (cmd_total_byte == '0) ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ffv_ok && credit_ok) begin
                        ffrreq  = 1'b1;
                        ffrbyte = n_c;
                        if (rem_q == LENW'(n_c)) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if ((occ == 2'd0) && !pend_q) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Command bookkeeping and the in-flight request's size/last tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q       <= '0;
            chunk_q     <= '0;
            pend_q      <= 1'b0;
            pend_n_q    <= '0;
            pend_last_q <= 1'b0;
        end else begin
            pend_q <= ffrreq;
            if (accept) begin
                rem_q   <= cmd_total_byte;
                chunk_q <= cmd_chunk_byte;
            end
            if (ffrreq) begin
                rem_q       <= rem_q - LENW'(n_c);
                pend_n_q    <= n_c;
                pend_last_q <= (rem_q == LENW'(n_c));
            end
        end
    end

    // Zero every byte beyond the requested count.
    always_comb begin
        masked = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (i < 32'(pend_n_q)) begin
                masked[i*8 +: 8] = ffrdata[i*8 +: 8];
            end
        end
    end

    // Data returning after a reset has no matching request and is dropped.
    assign push           = ffrvld & pend_q;
    assign push_ent.data  = masked;
    assign push_ent.nbyte = pend_n_q;
    assign push_ent.last  = pend_last_q;

    rshp_skid2 #(
        .W($bits(rshp_ent_t))
    ) u_q (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (push),
        .in_rdy   (unused_in_rdy),
        .in_data  (push_ent),
        .out_vld  (q_out_vld),
        .out_rdy  (out_rdy),
        .out_data (head_ent),
        .occ      (occ)
    );

    assign out_vld  = q_out_vld;
    assign out_data = head_ent.data;
    assign out_byte = head_ent.nbyte;
    assign out_last = head_ent.last;

endmodule

// File: tb/tb_rshp_rd_ctrl.sv
// Directed bench for rshp_rd_ctrl with a small byte-stream FIFO model.
module tb_rshp_rd_ctrl;

    localparam int unsigned DW   = 512;
    localparam int unsigned LENW = 24;
    localparam int unsigned BW   = rshp_pkg::bytew(DW);
    localparam int unsigned VBW  = rshp_pkg::vbytew(DW);
    localparam int unsigned NB   = DW / 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_vld;
    logic            cmd_rdy;
    logic [LENW-1:0] cmd_total_byte;
    logic [BW-1:0]   cmd_chunk_byte;
    logic [VBW-1:0]  ffvbyte;
    logic            ffrempty;
    logic            ffrreq;
    logic [BW-1:0]   ffrbyte;
    logic [DW-1:0]   ffrdata = '0;
    logic            ffrvld = 1'b0;
    logic            out_vld;
    logic            out_rdy;
    logic [DW-1:0]   out_data;
    logic [BW-1:0]   out_byte;
    logic            out_last;
    logic            done;

    rshp_rd_ctrl #(.DW(DW), .LENW(LENW)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_vld        (cmd_vld),
        .cmd_rdy        (cmd_rdy),
        .cmd_total_byte (cmd_total_byte),
        .cmd_chunk_byte (cmd_chunk_byte),
        .ffvbyte        (ffvbyte),
        .ffrempty       (ffrempty),
        .ffrreq         (ffrreq),
        .ffrbyte        (ffrbyte),
        .ffrdata        (ffrdata),
        .ffrvld         (ffrvld),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy),
        .out_data       (out_data),
        .out_byte       (out_byte),
        .out_last       (out_last),
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: byte k of the stream is pat(k), or 0xFF in ff_all mode.
    logic          auto_fill = 1'b1;
    logic          ff_all    = 1'b0;
    logic          ptr_clr   = 1'b0;
    int            man_level = 0;
    int            rd_ptr    = 0;
    int            cyc       = 0;
    logic          neg_req   = 1'b0;
    logic [BW-1:0] neg_n     = '0;

    function automatic logic [7:0] pat(input int k);
        return 8'((k * 37 + 11) & 255);
    endfunction

    function automatic logic [DW-1:0] fifo_word(input int p, input logic all1);
        logic [DW-1:0] w;
        for (int i = 0; i < NB; i++) w[i*8 +: 8] = all1 ? 8'hFF : pat(p + i);
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_beat(input int p, input int n);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i*8 +: 8] = pat(p + i);
        return w;
    endfunction

    assign ffvbyte = auto_fill ? VBW'(128) : VBW'(man_level - rd_ptr);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ptr_clr) rd_ptr <= 0;
        else if (neg_req) rd_ptr <= rd_ptr + int'(neg_n);
        ffrvld <= neg_req;
        if (neg_req) ffrdata <= fifo_word(rd_ptr, ff_all);
    end

    // Monitor: samples mid-cycle, logs requests, beats and done pulses.
    typedef struct {
        logic [DW-1:0] data;
        int            nbyte;
        logic          last;
        int            c;
    } beat_t;

    beat_t beat_q[$];
    int    req_n_q[$];
    int    req_c_q[$];
    int    done_q[$];
    int    vld_cnt  = 0;
    int    full_cnt = 0;

    always @(negedge clk) begin
        neg_req <= ffrreq;
        neg_n   <= ffrbyte;
        if (!reset) begin
            if (ffrreq) begin
                req_n_q.push_back(int'(ffrbyte));
                req_c_q.push_back(cyc);
            end
            if (out_vld) vld_cnt <= vld_cnt + 1;
            if (out_vld && out_rdy) beat_q.push_back('{out_data, int'(out_byte), out_last, cyc});
            if (done) done_q.push_back(cyc);
            if (ffrvld && (u_dut.occ == 2'd2)) full_cnt <= full_cnt + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ptr;
        ptr_clr = 1'b1;
        step();
        ptr_clr = 1'b0;
    endtask

    task automatic send_cmd(input int total, input int chunk, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        cmd_vld        = 1'b1;
        cmd_total_byte = LENW'(total);
        cmd_chunk_byte = BW'(chunk);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_rdy) begin
                ok  = 1'b1;
                acc = cyc;
            end
        end
        if (!ok) check("cmd_accept_timeout", DW'(0), DW'(1));
        step();
        cmd_vld = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        bit ok;
        ok = 1'b0;
        dc = -1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                dc = cyc;
            end
        end
        if (!ok) check("done_timeout", DW'(0), DW'(1));
        step();
    endtask

    logic [DW-1:0] run1 [4];
    int exp_n [4] = '{64, 64, 64, 8};

    initial begin
        int acc, dc, b0, r0, d0, vc0;
        reset = 1'b1; cmd_vld = 1'b0; cmd_total_byte = '0; cmd_chunk_byte = '0;
        out_rdy = 1'b1; ffrempty = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_rdy_low", DW'(cmd_rdy), DW'(0));
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_rdy", DW'(cmd_rdy), DW'(1));
        check("rst_out_vld", DW'(out_vld), DW'(0));
        check("rst_ffrreq", DW'(ffrreq), DW'(0));
        check("rst_ffrbyte", DW'(ffrbyte), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_out_byte", DW'(out_byte), DW'(0));
        check("rst_out_last", DW'(out_last), DW'(0));
        check("rst_out_data", out_data, '0);
        step();

        // 200 bytes in 64-byte chunks, free-running output
        clr_ptr();
        b0 = beat_q.size(); r0 = req_n_q.size();
        send_cmd(200, 64, acc);
        wait_done(dc);
        check("t1_nreq", DW'(req_n_q.size() - r0), DW'(4));
        check("t1_nbeat", DW'(beat_q.size() - b0), DW'(4));
        if (req_n_q.size() - r0 == 4) begin
            for (int k = 0; k < 4; k++) check("t1_ffrbyte", DW'(req_n_q[r0+k]), DW'(exp_n[k]));
            check("t1_req_first_cyc", DW'(req_c_q[r0]), DW'(acc + 1));
            check("t1_req_last_cyc", DW'(req_c_q[r0+3]), DW'(acc + 4));
        end
        if (beat_q.size() - b0 == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t1_out_byte", DW'(beat_q[b0+k].nbyte), DW'(exp_n[k]));
                check("t1_out_last", DW'(beat_q[b0+k].last), DW'(k == 3));
                check("t1_out_data", beat_q[b0+k].data, exp_beat(64 * k, exp_n[k]));
                run1[k] = beat_q[b0+k].data;
            end
            check("t1_done_cyc", DW'(dc), DW'(beat_q[b0+3].c + 1));
        end

        // Same command, output stalled for 10 cycles
        clr_ptr();
        b0 = beat_q.size(); r0 = req_n_q.size(); d0 = done_q.size();
        out_rdy = 1'b0;
        send_cmd(200, 64, acc);
        repeat (9) step();
        @(negedge clk);
        check("t2_stall_req_le2", DW'((req_n_q.size() - r0) <= 2), DW'(1));
        check("t2_stall_vld", DW'(out_vld), DW'(1));
        check("t2_stall_head_byte", DW'(out_byte), DW'(64));
        check("t2_stall_head_data", out_data, exp_beat(0, 64));
        step();
        out_rdy = 1'b1;
        wait_done(dc);
        check("t2_nbeat", DW'(beat_q.size() - b0), DW'(4));
        check("t2_ndone", DW'(done_q.size() - d0), DW'(1));
        if (beat_q.size() - b0 == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t2_data_vs_run1", beat_q[b0+k].data, run1[k]);
                check("t2_out_byte", DW'(beat_q[b0+k].nbyte), DW'(exp_n[k]));
                check("t2_out_last", DW'(beat_q[b0+k].last), DW'(k == 3));
            end
        end

        // Insufficient FIFO bytes hold off the request
        auto_fill = 1'b0; man_level = 30;
        clr_ptr();
        b0 = beat_q.size();
        send_cmd(32, 32, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_ffrreq", DW'(ffrreq), DW'(0));
        end
        step();
        man_level = 32;
        @(negedge clk);
        check("t3_ffrreq", DW'(ffrreq), DW'(1));
        check("t3_ffrbyte", DW'(ffrbyte), DW'(32));
        step();
        wait_done(dc);
        check("t3_nbeat", DW'(beat_q.size() - b0), DW'(1));
        if (beat_q.size() - b0 == 1) begin
            check("t3_out_byte", DW'(beat_q[b0].nbyte), DW'(32));
            check("t3_out_last", DW'(beat_q[b0].last), DW'(1));
            check("t3_out_data", beat_q[b0].data, exp_beat(0, 32));
        end
        auto_fill = 1'b1;

        // Zero-length command
        b0 = beat_q.size(); vc0 = vld_cnt;
        send_cmd(0, 64, acc);
        check("t4_accepted", DW'(acc >= 0), DW'(1));
        @(negedge clk);
        check("t4_done_pulse", DW'(done), DW'(1));
        check("t4_out_vld", DW'(out_vld), DW'(0));
        step();
        @(negedge clk);
        check("t4_done_clear", DW'(done), DW'(0));
        check("t4_cmd_rdy", DW'(cmd_rdy), DW'(1));
        check("t4_no_beats", DW'(beat_q.size() - b0), DW'(0));
        check("t4_no_vld", DW'(vld_cnt - vc0), DW'(0));
        step();

        // Tail masking with an all-ones FIFO
        ff_all = 1'b1;
        clr_ptr();
        b0 = beat_q.size();
        send_cmd(72, 64, acc);
        wait_done(dc);
        check("t5_nbeat", DW'(beat_q.size() - b0), DW'(2));
        if (beat_q.size() - b0 == 2) begin
            check("t5_b1_data", beat_q[b0].data, {DW{1'b1}});
            check("t5_b2_byte", DW'(beat_q[b0+1].nbyte), DW'(8));
            check("t5_b2_last", DW'(beat_q[b0+1].last), DW'(1));
            check("t5_b2_lo", DW'(beat_q[b0+1].data[63:0]), DW'(64'hFFFF_FFFF_FFFF_FFFF));
            check("t5_b2_hi", DW'(beat_q[b0+1].data[DW-1:64]), DW'(0));
        end
        ff_all = 1'b0;

        // Reset in the middle of a stalled command
        clr_ptr();
        d0 = done_q.size();
        out_rdy = 1'b0;
        send_cmd(200, 64, acc);
        repeat (5) step();
        @(negedge clk);
        check("t6_pre_vld", DW'(out_vld), DW'(1));
        step();
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_cmd_rdy", DW'(cmd_rdy), DW'(0));
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t6_post_vld", DW'(out_vld), DW'(0));
        check("t6_post_ffrreq", DW'(ffrreq), DW'(0));
        check("t6_post_done", DW'(done), DW'(0));
        check("t6_post_cmd_rdy", DW'(cmd_rdy), DW'(1));
        step();
        out_rdy = 1'b1;
        clr_ptr();
        b0 = beat_q.size();
        send_cmd(72, 64, acc);
        wait_done(dc);
        check("t6_ndone", DW'(done_q.size() - d0), DW'(1));
        check("t6_nbeat", DW'(beat_q.size() - b0), DW'(2));
        if (beat_q.size() - b0 == 2) begin
            check("t6_b1_data", beat_q[b0].data, exp_beat(0, 64));
            check("t6_b1_last", DW'(beat_q[b0].last), DW'(0));
            check("t6_b2_data", beat_q[b0+1].data, exp_beat(64, 8));
            check("t6_b2_last", DW'(beat_q[b0+1].last), DW'(1));
        end

        check("no_push_full", DW'(full_cnt), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
